// File: rtl/ram_bank.sv
// ram_bank: byte-strobed single-write/single-read RAM with a registered read port
// and a post-reset sequence that zeroes every word before accepting traffic.
module ram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 256,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   wstrb_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              init_busy_o,
    output logic              err_o
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_word, fwd_word;
    logic              rvalid_q, rvalid_d, err_q, err_d;
    logic              clr, run, w_in, r_in, wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_C) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        clr         = state_q == INIT;
        run         = state_q == RUN;
        init_busy_o = clr;
    end

    // Write-first forwarding: strobed lanes of a same-address write override the stored word
    always_comb begin
        w_in    = {1'b0, waddr_i} < DEPTH_C;
        r_in    = {1'b0, raddr_i} < DEPTH_C;
        wr_en   = run && we_i && w_in;
        rd_word = r_in ? mem[raddr_i] : '0;
        for (int k = 0; k < BE_W; k++)
            fwd_word[8*k +: 8] = (wr_en && waddr_i == raddr_i && wstrb_i[k]) ? wdata_i[8*k +: 8] : rd_word[8*k +: 8];
        rvalid_d = run && re_i;
        err_d    = run && ((we_i && !w_in) || (re_i && !r_in));
        rdata_d  = rvalid_d ? fwd_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (clr)
            mem[cnt_q] <= '0;
        else if (wr_en)
            for (int k = 0; k < BE_W; k++)
                if (wstrb_i[k]) mem[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: drives identical traffic into a 16-word and a 12-word bank and
// compares every cycle against a scoreboard fed by a behavioural model.
module tb_ram_bank;
    logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, re = 1'b0;
    logic [3:0]  wa = '0, ra = '0, ws = '0;
    logic [31:0] wd = '0;
    logic [31:0] rdata [2];
    logic        rvalid [2], busy [2], err [2];

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    int          dep [2] = '{16, 12};
    int          rem [2];
    logic [31:0] mm [2][16];
    logic [31:0] last [2];

    always #5 clk = ~clk;

    ram_bank #(.DATA_W(32), .DEPTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(wa), .wdata_i(wd), .wstrb_i(ws),
        .re_i(re), .raddr_i(ra), .rdata_o(rdata[0]), .rvalid_o(rvalid[0]),
        .init_busy_o(busy[0]), .err_o(err[0])
    );

    ram_bank #(.DATA_W(32), .DEPTH(12)) u_d12 (
        .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(wa), .wdata_i(wd), .wstrb_i(ws),
        .re_i(re), .raddr_i(ra), .rdata_o(rdata[1]), .rvalid_o(rvalid[1]),
        .init_busy_o(busy[1]), .err_o(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i]  = dep[i];
            last[i] = '0;
            for (int a = 0; a < 16; a++) mm[i][a] = '0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rvalid%0d", i), rvalid[i], 0);
            check($sformatf("rst_err%0d", i), err[i], 0);
            check($sformatf("rst_busy%0d", i), busy[i], 1);
            check($sformatf("rst_rdata%0d", i), rdata[i], 0);
        end
    endtask

    task automatic cycle(input logic w, input logic [3:0] a_w, input logic [31:0] d,
                         input logic [3:0] s, input logic r, input logic [3:0] a_r);
        exp_t        e;
        logic [31:0] v;
        we = w; wa = a_w; wd = d; ws = s; re = r; ra = a_r;
        for (int i = 0; i < 2; i++) begin
            e   = '0;
            e.d = last[i];
            if (rem[i] == 0) begin
                e.e = (w && a_w >= dep[i]) || (r && a_r >= dep[i]);
                e.v = r;
                if (r) begin
                    v = (a_r < dep[i]) ? mm[i][a_r] : 32'h0;
                    if (w && a_w == a_r && a_w < dep[i])
                        for (int k = 0; k < 4; k++) if (s[k]) v[8*k +: 8] = d[8*k +: 8];
                    e.d     = v;
                    last[i] = v;
                end
                if (w && a_w < dep[i])
                    for (int k = 0; k < 4; k++) if (s[k]) mm[i][a_w][8*k +: 8] = d[8*k +: 8];
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            if (rem[i] > 0) rem[i]--;
            check($sformatf("rvalid%0d", i), rvalid[i], e.v);
            check($sformatf("err%0d", i), err[i], e.e);
            check($sformatf("rdata%0d", i), rdata[i], e.d);
            check($sformatf("busy%0d", i), busy[i], rem[i] > 0);
        end
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, a);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        cycle(1'b1, a, d, s, 1'b0, 4'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        // Traffic during INIT must be ignored entirely
        for (int c = 0; c < 16; c++)
            cycle(1'b1, 4'($urandom_range(0, 15)), 32'hFFFFFFFF, 4'hF, 1'b1, 4'($urandom_range(0, 15)));
        for (int a = 0; a < 16; a++) rd(4'(a));
        wr(4'd5, 32'hAABBCCDD, 4'b1111);
        wr(4'd5, 32'h11223344, 4'b0101);
        rd(4'd5);
        check("lanes_a5", rdata[0], 32'hAA22CC44);
        cycle(1'b1, 4'd3, 32'hDEADBEEF, 4'b0011, 1'b1, 4'd3);
        check("wfirst_a3", rdata[0], 32'h0000BEEF);
        rd(4'd3);
        check("after_a3", rdata[0], 32'h0000BEEF);
        wr(4'd13, 32'h12345678, 4'hF);
        check("oor_wr_err", err[1], 1);
        rd(4'd13);
        check("oor_rd_err", err[1], 1);
        check("oor_rd_data", rdata[1], 0);
        for (int a = 0; a < 12; a++) rd(4'(a));
        cycle(1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 4'd5);
        cycle(1'b1, 4'd14, 32'h0BADBEEF, 4'hF, 1'b1, 4'd15);
        cycle(1'b1, 4'd9, 32'h55AA55AA, 4'h0, 1'b1, 4'd7);
        for (int c = 0; c < 150; c++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        for (int a = 0; a < 16; a++) wr(4'(a), 32'hFFFFFFFF, 4'hF);
        for (int a = 0; a < 4; a++) rd(4'(a));
        // Asynchronous reset in the middle of a read stream
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 16; c++) rd(4'(c));
        for (int a = 0; a < 16; a++) rd(4'(a));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
